// File: rtl/id_stage.sv
// Instruction-decode stage of the RV32I pipeline. Decodes the IF/ID
// instruction, drives the register-file read addresses, builds the
// immediate, detects load-use hazards against EX and loads ID/EX.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            async_rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            stall_in,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_src_pc,
  output logic            ex_src_imm,
  output logic [2:0]      ex_kind,
  output logic [2:0]      ex_funct3,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    KIND_ALU    = 3'd0,
    KIND_LOAD   = 3'd1,
    KIND_STORE  = 3'd2,
    KIND_BRANCH = 3'd3,
    KIND_JAL    = 3'd4,
    KIND_JALR   = 3'd5
  } kind_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  // Immediate assembly; every format sign-extends from instr[31].
  function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                                     input imm_fmt_e fmt);
    logic signed [XLEN-1:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic                   dec_legal;
  logic                   dec_writes;
  logic                   dec_uses_rs1;
  logic                   dec_uses_rs2;
  logic                   dec_src_pc;
  logic                   dec_src_imm;
  logic                   dec_zero_op1;
  logic [3:0]             dec_alu_op;
  kind_e                  dec_kind;
  imm_fmt_e               dec_fmt;
  logic signed [XLEN-1:0] dec_imm;
  logic [4:0]             dec_rd;
  logic                   hazard;

  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [XLEN-1:0]        op1_p1;
  logic [XLEN-1:0]        op2_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [4:0]             rd_p1;
  logic [3:0]             alu_op_p1;
  logic                   src_pc_p1;
  logic                   src_imm_p1;
  logic [2:0]             kind_p1;
  logic [2:0]             funct3_p1;
  logic                   reg_write_p1;
  logic                   illegal_p1;

  assign opcode   = id_instr[6:0];
  assign funct3   = id_instr[14:12];
  assign rs1_addr = id_instr[19:15];
  assign rs2_addr = id_instr[24:20];

  // Opcode decode into control fields; illegal encodings decode to zeros.
  always_comb begin
    dec_legal    = 1'b1;
    dec_writes   = 1'b0;
    dec_uses_rs1 = 1'b0;
    dec_uses_rs2 = 1'b0;
    dec_src_pc   = 1'b0;
    dec_src_imm  = 1'b0;
    dec_zero_op1 = 1'b0;
    dec_alu_op   = 4'b0000;
    dec_kind     = KIND_ALU;
    dec_fmt      = FMT_NONE;
    case (opcode)
      OPC_OP: begin
        dec_writes = 1'b1; dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1;
        dec_alu_op = {id_instr[30], funct3};
      end
      OPC_OP_IMM: begin
        dec_writes = 1'b1; dec_uses_rs1 = 1'b1; dec_src_imm = 1'b1;
        dec_fmt    = FMT_I;
        dec_alu_op = (funct3 == 3'b101) ? {id_instr[30], funct3} : {1'b0, funct3};
      end
      OPC_LOAD: begin
        dec_writes = 1'b1; dec_uses_rs1 = 1'b1; dec_src_imm = 1'b1;
        dec_fmt    = FMT_I; dec_kind = KIND_LOAD;
      end
      OPC_STORE: begin
        dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1; dec_src_imm = 1'b1;
        dec_fmt      = FMT_S; dec_kind = KIND_STORE;
      end
      OPC_BRANCH: begin
        dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1;
        dec_fmt      = FMT_B; dec_kind = KIND_BRANCH; dec_alu_op = 4'b1000;
      end
      OPC_JAL: begin
        dec_writes = 1'b1; dec_src_pc = 1'b1; dec_src_imm = 1'b1;
        dec_fmt    = FMT_J; dec_kind = KIND_JAL;
      end
      OPC_JALR: begin
        dec_writes = 1'b1; dec_uses_rs1 = 1'b1; dec_src_imm = 1'b1;
        dec_fmt    = FMT_I; dec_kind = KIND_JALR;
      end
      OPC_LUI: begin
        dec_writes = 1'b1; dec_src_imm = 1'b1; dec_zero_op1 = 1'b1;
        dec_fmt    = FMT_U;
      end
      OPC_AUIPC: begin
        dec_writes = 1'b1; dec_src_pc = 1'b1; dec_src_imm = 1'b1;
        dec_fmt    = FMT_U;
      end
      OPC_FENCE: ;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_imm = gen_imm(id_instr, dec_fmt);
  // Stores and branches carry immediate bits in the rd field, so only
  // writing instructions report a destination.
  assign dec_rd  = dec_writes ? id_instr[11:7] : 5'd0;

  assign hazard   = vld_p1 && (kind_p1 == KIND_LOAD) && (rd_p1 != 5'd0) && id_valid &&
                    ((dec_uses_rs1 && (rs1_addr == rd_p1)) ||
                     (dec_uses_rs2 && (rs2_addr == rd_p1)));
  assign id_stall = stall_in | (hazard & ~flush);

  // ---- ID -> EX pipeline register ----
  // Hold on downstream stall, bubble on flush/hazard/empty slot, else capture.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      vld_p1 <= 1'b0; pc_p1 <= '0; op1_p1 <= '0; op2_p1 <= '0; imm_p1 <= '0;
      rd_p1 <= '0; alu_op_p1 <= '0; src_pc_p1 <= 1'b0; src_imm_p1 <= 1'b0;
      kind_p1 <= '0; funct3_p1 <= '0; reg_write_p1 <= 1'b0; illegal_p1 <= 1'b0;
    end else if (stall_in) begin
      vld_p1 <= vld_p1;
    end else if (flush || hazard || !id_valid) begin
      vld_p1 <= 1'b0; pc_p1 <= '0; op1_p1 <= '0; op2_p1 <= '0; imm_p1 <= '0;
      rd_p1 <= '0; alu_op_p1 <= '0; src_pc_p1 <= 1'b0; src_imm_p1 <= 1'b0;
      kind_p1 <= '0; funct3_p1 <= '0; reg_write_p1 <= 1'b0; illegal_p1 <= 1'b0;
    end else begin
      vld_p1       <= 1'b1;
      pc_p1        <= id_pc;
      op1_p1       <= (dec_legal && dec_zero_op1) ? '0 : rs1_data;
      op2_p1       <= rs2_data;
      imm_p1       <= dec_legal ? dec_imm : '0;
      rd_p1        <= dec_legal ? dec_rd : 5'd0;
      alu_op_p1    <= dec_legal ? dec_alu_op : 4'b0000;
      src_pc_p1    <= dec_legal & dec_src_pc;
      src_imm_p1   <= dec_legal & dec_src_imm;
      kind_p1      <= dec_legal ? dec_kind : KIND_ALU;
      funct3_p1    <= dec_legal ? funct3 : 3'b000;
      reg_write_p1 <= dec_legal & dec_writes & (dec_rd != 5'd0);
      illegal_p1   <= ~dec_legal;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_pc        = pc_p1;
  assign ex_op1       = op1_p1;
  assign ex_op2       = op2_p1;
  assign ex_imm       = imm_p1;
  assign ex_rd        = rd_p1;
  assign ex_alu_op    = alu_op_p1;
  assign ex_src_pc    = src_pc_p1;
  assign ex_src_imm   = src_imm_p1;
  assign ex_kind      = kind_p1;
  assign ex_funct3    = funct3_p1;
  assign ex_reg_write = reg_write_p1;
  assign ex_illegal   = illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by randomized traffic,
// compared against a field-level reference model of the ID/EX register.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, rs1_data, rs2_data;
  logic        flush, stall_in;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_src_pc, ex_src_imm;
  logic [2:0]  ex_kind, ex_funct3;
  logic        ex_reg_write, ex_illegal;

  int checks = 0;
  int errors = 0;
  logic stall_seen;

  typedef struct {
    bit        v;
    bit [31:0] pc, op1, op2, imm;
    bit [4:0]  rd;
    bit [3:0]  alu;
    bit        sp, si;
    bit [2:0]  kind, f3;
    bit        rw, ill;
  } ex_t;

  ex_t m;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .flush(flush), .stall_in(stall_in), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_src_pc(ex_src_pc),
    .ex_src_imm(ex_src_imm), .ex_kind(ex_kind), .ex_funct3(ex_funct3),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_op(input bit [31:0] i, input bit [6:0] o);
    return i[6:0] == o;
  endfunction

  function automatic bit legal(input bit [31:0] i);
    case (i[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit uses1(input bit [31:0] i);
    return legal(i) && !is_op(i, 7'b0110111) && !is_op(i, 7'b0010111) &&
           !is_op(i, 7'b1101111) && !is_op(i, 7'b0001111);
  endfunction

  function automatic bit uses2(input bit [31:0] i);
    return is_op(i, 7'b0110011) || is_op(i, 7'b0100011) || is_op(i, 7'b1100011);
  endfunction

  // Architectural meaning of one instruction, from the RV32I field rules.
  function automatic ex_t ref_decode(input bit [31:0] i, input bit [31:0] pc,
                                     input bit [31:0] r1, input bit [31:0] r2);
    ex_t e = '{default: 0};
    bit [31:0] neg12 = i[31] ? 32'd4096 : 32'd0;
    bit [31:0] imm_i = 32'(i[31:20]) - neg12;
    bit [31:0] imm_s = 32'(i[31:25]) * 32'd32 + 32'(i[11:7]) - neg12;
    bit [31:0] imm_b = 32'(i[11:8]) * 32'd2 + 32'(i[30:25]) * 32'd32 +
                       32'(i[7]) * 32'd2048 - neg12;
    bit [31:0] imm_u = 32'(i[31:12]) * 32'd4096;
    bit [31:0] imm_j = 32'(i[30:21]) * 32'd2 + 32'(i[20]) * 32'd2048 +
                       32'(i[19:12]) * 32'd4096 - (i[31] ? 32'd1048576 : 32'd0);
    bit writes = 1'b0;
    e.v = 1'b1; e.pc = pc; e.op1 = r1; e.op2 = r2;
    if (!legal(i)) begin
      e.ill = 1'b1;
      return e;
    end
    e.f3 = i[14:12];
    case (i[6:0])
      7'b0110011: begin writes = 1; e.alu = {i[30], i[14:12]}; end
      7'b0010011: begin
        writes = 1; e.si = 1; e.imm = imm_i;
        e.alu = (i[14:12] == 3'b101) ? {i[30], i[14:12]} : {1'b0, i[14:12]};
      end
      7'b0000011: begin writes = 1; e.si = 1; e.imm = imm_i; e.kind = 1; end
      7'b0100011: begin e.si = 1; e.imm = imm_s; e.kind = 2; end
      7'b1100011: begin e.imm = imm_b; e.kind = 3; e.alu = 4'b1000; end
      7'b1101111: begin writes = 1; e.sp = 1; e.si = 1; e.imm = imm_j; e.kind = 4; end
      7'b1100111: begin writes = 1; e.si = 1; e.imm = imm_i; e.kind = 5; end
      7'b0110111: begin writes = 1; e.si = 1; e.imm = imm_u; e.op1 = 0; end
      7'b0010111: begin writes = 1; e.sp = 1; e.si = 1; e.imm = imm_u; end
      default: ;
    endcase
    e.rd = writes ? i[11:7] : 5'd0;
    e.rw = writes && (e.rd != 0);
    return e;
  endfunction

  function automatic bit ref_hazard(input bit v, input bit [31:0] i);
    return m.v && m.kind == 3'd1 && m.rd != 0 && v &&
           ((uses1(i) && i[19:15] == m.rd) || (uses2(i) && i[24:20] == m.rd));
  endfunction

  task automatic check_all(input string pfx);
    chk({pfx, "ex_valid"}, 32'(ex_valid), 32'(m.v));
    chk({pfx, "ex_pc"}, ex_pc, m.pc);
    chk({pfx, "ex_op1"}, ex_op1, m.op1);
    chk({pfx, "ex_op2"}, ex_op2, m.op2);
    chk({pfx, "ex_imm"}, ex_imm, m.imm);
    chk({pfx, "ex_rd"}, 32'(ex_rd), 32'(m.rd));
    chk({pfx, "ex_alu_op"}, 32'(ex_alu_op), 32'(m.alu));
    chk({pfx, "ex_src_pc"}, 32'(ex_src_pc), 32'(m.sp));
    chk({pfx, "ex_src_imm"}, 32'(ex_src_imm), 32'(m.si));
    chk({pfx, "ex_kind"}, 32'(ex_kind), 32'(m.kind));
    chk({pfx, "ex_funct3"}, 32'(ex_funct3), 32'(m.f3));
    chk({pfx, "ex_reg_write"}, 32'(ex_reg_write), 32'(m.rw));
    chk({pfx, "ex_illegal"}, 32'(ex_illegal), 32'(m.ill));
  endtask

  // One pipeline cycle: drive after the falling edge, check the
  // combinational outputs, clock, advance the model, check ID/EX.
  task automatic cyc(input bit v, input bit [31:0] i, input bit [31:0] pc,
                     input bit [31:0] r1, input bit [31:0] r2,
                     input bit fl, input bit st);
    bit haz;
    @(negedge clk);
    id_valid = v; id_instr = i; id_pc = pc; rs1_data = r1; rs2_data = r2;
    flush = fl; stall_in = st;
    #1;
    haz = ref_hazard(v, i);
    stall_seen = id_stall;
    chk("id_stall", 32'(id_stall), 32'(st | (haz & ~fl)));
    chk("rs1_addr", 32'(rs1_addr), 32'(i[19:15]));
    chk("rs2_addr", 32'(rs2_addr), 32'(i[24:20]));
    @(posedge clk);
    if (st) m = m;
    else if (fl || haz || !v) m = '{default: 0};
    else m = ref_decode(i, pc, r1, r2);
    #1;
    check_all("");
  endtask

  localparam bit [31:0] ADDI   = 32'hFFF08293;
  localparam bit [31:0] LW_X3  = 32'h00012183;
  localparam bit [31:0] LW_X0  = 32'h00012003;
  localparam bit [31:0] ADD_D  = 32'h00118233;
  localparam bit [31:0] ADD_I  = 32'h00100233;
  localparam bit [31:0] SYSTEM = 32'h00000073;
  localparam bit [31:0] LUI_X7 = 32'h123453B7;

  initial begin
    bit [6:0] opcs [11];
    bit [31:0] ri;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
    async_rst_n = 1'b0; id_valid = 0; id_instr = 0; id_pc = 0;
    rs1_data = 0; rs2_data = 0; flush = 0; stall_in = 0;
    m = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    check_all("rst:");
    @(negedge clk);
    async_rst_n = 1'b1;

    // ADDI x5,x1,-1
    cyc(1, ADDI, 32'h100, 32'd10, 32'd0, 0, 0);
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_rd", 32'(ex_rd), 32'd5);
    chk("addi_op1", ex_op1, 32'd10);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_src_imm", 32'(ex_src_imm), 32'd1);
    chk("addi_alu", 32'(ex_alu_op), 32'd0);
    chk("addi_rw", 32'(ex_reg_write), 32'd1);

    // Mid-stream asynchronous reset with no clock edge
    @(negedge clk); #2;
    async_rst_n = 1'b0; #1;
    m = '{default: 0};
    check_all("async_rst:");
    chk("async_rst_stall", 32'(id_stall), 32'(stall_in));
    @(negedge clk); async_rst_n = 1'b1;

    // Load-use: one bubble then the dependent ADD proceeds
    cyc(1, LW_X3, 32'h200, 32'd0, 32'd0, 0, 0);
    cyc(1, ADD_D, 32'h204, 32'd7, 32'd8, 0, 0);
    chk("lu_stall", 32'(stall_seen), 32'd1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    cyc(1, ADD_D, 32'h204, 32'd7, 32'd8, 0, 0);
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_alu", 32'(ex_alu_op), 32'd0);
    chk("lu_add_rd", 32'(ex_rd), 32'd4);

    // Independent ADD after load, and load to x0
    cyc(1, LW_X3, 32'h300, 32'd0, 32'd0, 0, 0);
    cyc(1, ADD_I, 32'h304, 32'd0, 32'd1, 0, 0);
    chk("nodep_stall", 32'(stall_seen), 32'd0);
    cyc(1, LW_X0, 32'h308, 32'd0, 32'd0, 0, 0);
    cyc(1, ADD_I, 32'h30C, 32'd0, 32'd1, 0, 0);
    chk("x0_stall", 32'(stall_seen), 32'd0);

    // Flush, alone and with a simultaneous load-use hazard
    cyc(1, ADDI, 32'h400, 32'd3, 32'd0, 1, 0);
    chk("flush_bubble", 32'(ex_valid), 32'd0);
    cyc(1, LW_X3, 32'h404, 32'd0, 32'd0, 0, 0);
    cyc(1, ADD_D, 32'h408, 32'd0, 32'd0, 1, 0);
    chk("flush_haz_stall", 32'(stall_seen), 32'd0);
    chk("flush_haz_bubble", 32'(ex_valid), 32'd0);

    // Downstream stall for three cycles with a flush pulse in the middle
    cyc(1, ADDI, 32'h500, 32'd10, 32'd0, 0, 0);
    cyc(1, LUI_X7, 32'h504, 32'd1, 32'd2, 0, 1);
    chk("st1_stall", 32'(stall_seen), 32'd1);
    cyc(1, LUI_X7, 32'h504, 32'd1, 32'd2, 1, 1);
    chk("st2_stall", 32'(stall_seen), 32'd1);
    cyc(1, LUI_X7, 32'h504, 32'd1, 32'd2, 0, 1);
    chk("st3_stall", 32'(stall_seen), 32'd1);
    chk("st_hold_rd", 32'(ex_rd), 32'd5);
    chk("st_hold_imm", ex_imm, 32'hFFFFFFFF);

    // Illegal SYSTEM opcode, then LUI
    cyc(1, SYSTEM, 32'h600, 32'd1, 32'd2, 0, 0);
    chk("sys_illegal", 32'(ex_illegal), 32'd1);
    chk("sys_rw", 32'(ex_reg_write), 32'd0);
    cyc(1, LUI_X7, 32'h604, 32'h0000DEAD, 32'd0, 0, 0);
    chk("lui_op1", ex_op1, 32'd0);
    chk("lui_imm", ex_imm, 32'h12345000);

    // Reset asserted during a load-use stall
    cyc(1, LW_X3, 32'h700, 32'd0, 32'd0, 0, 0);
    @(negedge clk);
    id_valid = 1; id_instr = ADD_D; id_pc = 32'h704; rs1_data = 32'd9; rs2_data = 32'd4;
    #1;
    chk("pre_rst_stall", 32'(id_stall), 32'd1);
    async_rst_n = 1'b0; #1;
    m = '{default: 0};
    check_all("stall_rst:");
    chk("stall_rst_id_stall", 32'(id_stall), 32'd0);
    stall_in = 1'b1; #1;
    chk("stall_rst_follow", 32'(id_stall), 32'd1);
    stall_in = 1'b0;
    @(negedge clk); async_rst_n = 1'b1;
    cyc(1, ADD_D, 32'h704, 32'd9, 32'd4, 0, 0);
    chk("post_rst_add", 32'(ex_rd), 32'd4);

    // Randomized traffic with small register numbers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 15) != 0) begin
        ri[6:0] = opcs[$urandom_range(0, 10)];
        ri[11:7] = 5'($urandom_range(0, 4));
        ri[19:15] = 5'($urandom_range(0, 4));
        ri[24:20] = 5'($urandom_range(0, 4));
      end
      cyc($urandom_range(0, 9) != 0, ri, $urandom, $urandom, $urandom,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I pipelined core, between the IF/ID register and the execute stage. It decodes the instruction and drives the two register-file read addresses combinationally. It generates the immediate, detects load-use hazards against the instruction currently in EX, and captures everything into the ID/EX pipeline register. It consumes the register file's combinational read data in the same cycle.

## Interface
- XLEN, 32: data/address width; only 32 is supported.
- clk  in  1  pipeline clock; ID/EX updates on rising edge.
- async_rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  32  instruction word.
- id_pc  in  32  PC of id_instr.
- rs1_addr  out  5  id_instr[19:15]; to register file operand 1 address.
- rs2_addr  out  5  id_instr[24:20]; to register file operand 2 address.
- rs1_data  in  32  register file operand 1.
- rs2_data  in  32  register file operand 2.
- flush  in  1  taken branch/jump resolved in EX; kill the instruction in ID.
- stall_in  in  1  downstream stall; freeze ID/EX.
- id_stall  out  1  hold PC and IF/ID.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc, ex_op1, ex_op2, ex_imm  out  32 each  PC, rs1 value, rs2 value, immediate.
- ex_rd  out  5  destination register.
- ex_alu_op  out  4  ALU operation.
- ex_src_pc  out  1  ALU A = ex_pc.
- ex_src_imm  out  1  ALU B = ex_imm.
- ex_kind  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR.
- ex_funct3  out  3  instr[14:12], for branch condition and memory size.
- ex_reg_write  out  1  writeback enable.
- ex_illegal  out  1  illegal instruction.

## Operation
- Decoded opcodes:
  - OP 0110011
  - OP-IMM 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
  - LUI 0110111
  - AUIPC 0010111
  - FENCE 0001111, treated as a NOP: valid, no write.
- Illegal instructions: any other opcode, or instr[1:0] != 2'b11. Response: ex_illegal=1, ex_reg_write=0, ex_kind=0.
- Immediates, all sign-extended from instr[31]:
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC; value is instr[31:12]<<12.
  - J-type: JAL.
  - R-type and FENCE: ex_imm = 0.
- ex_alu_op:
  - OP: {instr[30], funct3}.
  - OP-IMM with funct3 = 101: {instr[30], funct3}.
  - Other OP-IMM: {1'b0, funct3}.
  - BRANCH: 4'b1000 (SUB).
  - All others: 4'b0000 (ADD).
- ex_src_pc = 1 for AUIPC and JAL.
- ex_src_imm = 1 for OP-IMM, LOAD, STORE, JALR, LUI, AUIPC, JAL.
- LUI: ex_op1 forced to 0.
- ex_reg_write = 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC, only when rd != 0.
- Register usage for hazard checks:
  - uses_rs1: all legal opcodes except LUI, AUIPC, JAL, FENCE.
  - uses_rs2: OP, STORE, BRANCH.
- Load-use hazard: ex_valid & (ex_kind==LOAD) & (ex_rd!=0) & id_valid & ((uses_rs1 & rs1_addr==ex_rd) | (uses_rs2 & rs2_addr==ex_rd)).
- id_stall = stall_in | (hazard & ~flush). Combinational.
- ID/EX update priority at each posedge:
  1. stall_in=1: hold all fields; flush is ignored. EX guarantees flush only with stall_in=0.
  2. flush=1: load a bubble.
  3. hazard=1: load a bubble; IF/ID holds via id_stall.
  4. id_valid=0: load a bubble.
  5. Otherwise: capture the decoded instruction with ex_valid=1.
- Bubble: every ID/EX field is zero.
- No writeback bypass is needed. The register file writes on the falling edge, so a value written in the same cycle is already visible on rs*_data before the rising edge.

## Timing
- During async_rst_n=0, immediately and independent of clk: all ex_* outputs 0, and id_stall = stall_in.
- Combinational paths: rs1_addr and rs2_addr from id_instr; id_stall from inputs and ID/EX state.
- Latency: one cycle, ID to ex_* outputs.
- Load-use costs exactly one bubble. The next cycle ex_kind != LOAD, so the hazard clears and the held instruction proceeds.
- Back-to-back dependent ALU instructions: no stall; EX forwarding is EX's responsibility.
- Reset asserted mid-stall: the bubble state takes effect immediately; after release, decoding resumes from the IF/ID contents.

## Test plan
- Reset: assert async_rst_n=0 mid-stream without a clock edge -> ex_valid=0 and all ex_* = 0 immediately.
- ADDI x5,x1,-1 (0xFFF08293), rs1_data=10 -> next cycle:
  - ex_valid=1, ex_rd=5, ex_op1=10, ex_imm=0xFFFFFFFF
  - ex_src_imm=1, ex_alu_op=0000, ex_reg_write=1
- LW x3,0(x2) then ADD x4,x3,x1:
  - ADD cycle in ID: id_stall=1.
  - Following cycle: ex_valid=0 (bubble).
  - Cycle after: ADD in ID/EX with alu_op 0000, rd=4.
- Same LW followed by ADD x4,x0,x1 -> no stall. Repeat with LW rd=x0 -> no stall.
- flush=1 while an instruction is in ID -> bubble next cycle. With a simultaneous load-use hazard -> id_stall=0.
- stall_in=1 for 3 cycles with flush pulsed -> ID/EX unchanged and id_stall=1 throughout.
- Opcode 1110011 (SYSTEM) -> ex_illegal=1, ex_reg_write=0.
- LUI x7,0x12345 with rs1_data=0xDEAD -> ex_op1=0, ex_imm=0x12345000.
